// File: rtl/microcode_sequencer_if.sv
// Bus bundle between a host and the microcode sequencer: instruction and
// flag inputs, run control, microcode write port and the sequencer outputs.
interface microcode_sequencer_if #(
    parameter int OP_W   = 4,
    parameter int FLAG_W = 2,
    parameter int STEP_W = 3,
    parameter int CTRL_W = 18
);
    localparam int AW = OP_W + FLAG_W + STEP_W;

    logic [OP_W-1:0]   opcode;
    logic [FLAG_W-1:0] flags_in;
    logic              flags_we;
    logic              start;
    logic              abort;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [CTRL_W:0]   wr_data;
    logic [CTRL_W-1:0] ctrl_out;
    logic [STEP_W-1:0] step_out;
    logic              fetch;
    logic              halted;
    logic              wr_err;

    modport master (
        output opcode, flags_in, flags_we, start, abort, wr_en, wr_addr, wr_data,
        input  ctrl_out, step_out, fetch, halted, wr_err
    );

    modport slave (
        input  opcode, flags_in, flags_we, start, abort, wr_en, wr_addr, wr_data,
        output ctrl_out, step_out, fetch, halted, wr_err
    );
endinterface

// File: rtl/microcode_sequencer.sv
// Microcode sequencer: steps through a writable control store addressed by
// {opcode, latched flags, step}. Each word carries an END bit above the
// control bits; a designated control bit halts the sequencer.
module microcode_sequencer #(
    parameter int OP_W    = 4,
    parameter int FLAG_W  = 2,
    parameter int STEP_W  = 3,
    parameter int CTRL_W  = 18,
    parameter int HLT_BIT = 17
) (
    input logic                    clk,
    input logic                    rst_n,
    microcode_sequencer_if.slave   bus
);
    localparam int AW = OP_W + FLAG_W + STEP_W;
    localparam logic [STEP_W-1:0] STEP_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HALTED
    } state_t;

    state_t            state_q;
    logic [STEP_W-1:0] step_q;
    logic [FLAG_W-1:0] flags_q;
    logic              wr_err_q;

    logic [CTRL_W:0]   mem [0:(1<<AW)-1];
    logic [AW-1:0]     rd_addr;
    logic [CTRL_W:0]   word;
    logic              running;

    assign running = (state_q == S_RUN);
    assign rd_addr = {bus.opcode, flags_q, step_q};
    assign word    = mem[rd_addr];

    // Control store write port; writes are refused while an instruction runs
    always_ff @(posedge clk) begin
        if (bus.wr_en && !running) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Sequencer state, step counter, flag latch and write-error pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            step_q   <= '0;
            flags_q  <= '0;
            wr_err_q <= 1'b0;
        end else begin
            if (bus.flags_we) begin
                flags_q <= bus.flags_in;
            end
            wr_err_q <= bus.wr_en && running;

            if (bus.abort) begin
                state_q <= S_IDLE;
                step_q  <= '0;
            end else begin
                case (state_q)
                    S_IDLE, S_HALTED: begin
                        if (bus.start) begin
                            state_q <= S_RUN;
                            step_q  <= '0;
                        end
                    end
                    S_RUN: begin
                        if (word[HLT_BIT]) begin
                            state_q <= S_HALTED;
                            step_q  <= '0;
                        end else if (word[CTRL_W] || step_q == STEP_MAX) begin
                            step_q <= '0;
                        end else begin
                            step_q <= step_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        step_q  <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.ctrl_out = running ? word[CTRL_W-1:0] : '0;
    assign bus.step_out = step_q;
    assign bus.fetch    = running && (step_q == '0);
    assign bus.halted   = (state_q == S_HALTED);
    assign bus.wr_err   = wr_err_q;

endmodule

// File: tb/tb_microcode_sequencer.sv
// Bench for microcode_sequencer: a vector table covering plain sequencing and
// step wrap, plus hand-written sequences for flags, halt, refused writes,
// abort priority and asynchronous reset. Expected outputs go through a queue.
module tb_microcode_sequencer;
    localparam int OP_W   = 4;
    localparam int FLAG_W = 2;
    localparam int STEP_W = 3;
    localparam int CTRL_W = 18;
    localparam int AW     = OP_W + FLAG_W + STEP_W;

    localparam logic [CTRL_W:0] END_BIT = 19'h40000;
    localparam logic [CTRL_W:0] HLT     = 19'h20000;

    logic clk;
    logic rst_n;

    microcode_sequencer_if #(.OP_W(OP_W), .FLAG_W(FLAG_W), .STEP_W(STEP_W), .CTRL_W(CTRL_W)) bus ();

    microcode_sequencer #(
        .OP_W(OP_W), .FLAG_W(FLAG_W), .STEP_W(STEP_W), .CTRL_W(CTRL_W), .HLT_BIT(17)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [CTRL_W-1:0] ctrl;
        logic [STEP_W-1:0] step;
        logic              fetch;
        logic              halted;
        logic              wr_err;
    } exp_t;

    typedef struct {
        logic              start;
        logic              abort;
        logic [OP_W-1:0]   op;
        logic [CTRL_W-1:0] ctrl;
        logic [STEP_W-1:0] step;
        logic              fetch;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[16];
    int   total = 0;
    int   bad   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [CTRL_W-1:0] c, input logic [STEP_W-1:0] s,
                            input logic f, input logic h, input logic e);
        exp_t x;
        x.ctrl = c; x.step = s; x.fetch = f; x.halted = h; x.wr_err = e;
        sb.push_back(x);
    endtask

    task automatic check(input string name);
        exp_t x;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL %s: no expected record queued", name);
        end else begin
            x = sb.pop_front();
            if (bus.ctrl_out !== x.ctrl || bus.step_out !== x.step || bus.fetch !== x.fetch ||
                bus.halted !== x.halted || bus.wr_err !== x.wr_err) begin
                bad++;
                $display("FAIL %s: got ctrl=%h step=%0d fetch=%b halted=%b wr_err=%b, want ctrl=%h step=%0d fetch=%b halted=%b wr_err=%b",
                         name, bus.ctrl_out, bus.step_out, bus.fetch, bus.halted, bus.wr_err,
                         x.ctrl, x.step, x.fetch, x.halted, x.wr_err);
            end
        end
    endtask

    task automatic exp_chk(input string name, input logic [CTRL_W-1:0] c, input logic [STEP_W-1:0] s,
                           input logic f, input logic h, input logic e);
        push_exp(c, s, f, h, e);
        check(name);
    endtask

    task automatic write_word(input logic [OP_W-1:0] op, input logic [FLAG_W-1:0] fl,
                              input logic [STEP_W-1:0] st, input logic [CTRL_W:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_addr = {op, fl, st};
        bus.wr_data = data;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    // Watchdog: the bench is a fixed sequence, this only guards against a stuck clock
    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got still running, want finished");
        $fatal(1, "timeout");
    end

    initial begin
        bus.opcode = '0; bus.flags_in = '0; bus.flags_we = 1'b0;
        bus.start = 1'b0; bus.abort = 1'b0;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        rst_n = 1'b0;

        // Vector table: op1 three-step instruction, then op2 eight-step wrap
        vecs[0] = '{1'b1, 1'b0, 4'h1, 18'h00001, 3'd0, 1'b1};
        vecs[1] = '{1'b0, 1'b0, 4'h1, 18'h00002, 3'd1, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 4'h1, 18'h00004, 3'd2, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 4'h1, 18'h00001, 3'd0, 1'b1};
        vecs[4] = '{1'b0, 1'b1, 4'h1, 18'h00000, 3'd0, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 4'h2, 18'h00010, 3'd0, 1'b1};
        for (int unsigned k = 1; k < 8; k++) begin
            vecs[5+k] = '{(k == 1), 1'b0, 4'h2, 18'h00010 | 18'(k), 3'(k), 1'b0};
        end
        vecs[13] = '{1'b0, 1'b0, 4'h2, 18'h00010, 3'd0, 1'b1};
        vecs[14] = '{1'b0, 1'b0, 4'h2, 18'h00011, 3'd1, 1'b0};
        vecs[15] = '{1'b0, 1'b1, 4'h2, 18'h00000, 3'd0, 1'b0};

        #1;
        exp_chk("reset_state", '0, '0, 1'b0, 1'b0, 1'b0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        exp_chk("idle_after_reset", '0, '0, 1'b0, 1'b0, 1'b0);

        // Control store load, all in IDLE
        for (int unsigned i = 0; i < 8; i++) begin
            case (i)
                0: write_word(4'h1, 2'b00, 3'(i), 19'h00001);
                1: write_word(4'h1, 2'b00, 3'(i), 19'h00002);
                2: write_word(4'h1, 2'b00, 3'(i), END_BIT | 19'h00004);
                default: write_word(4'h1, 2'b00, 3'(i), END_BIT);
            endcase
            write_word(4'h2, 2'b00, 3'(i), 19'h00010 | 19'(i));
            write_word(4'h3, 2'b00, 3'(i), (i == 2) ? (END_BIT | 19'h00022) : 19'h00020 | 19'(i));
            write_word(4'h3, 2'b01, 3'(i), (i == 2) ? (END_BIT | 19'h00032) : 19'h00030 | 19'(i));
            write_word(4'h4, 2'b00, 3'(i), (i == 1) ? (HLT | 19'h00041) : 19'h00040 | 19'(i));
        end

        for (int i = 0; i < 16; i++) begin
            bus.start  = vecs[i].start;
            bus.abort  = vecs[i].abort;
            bus.opcode = vecs[i].op;
            tick();
            push_exp(vecs[i].ctrl, vecs[i].step, vecs[i].fetch, 1'b0, 1'b0);
            check($sformatf("vec%0d", i));
        end
        bus.start = 1'b0; bus.abort = 1'b0;

        // Flags latched during step 1 select the flags=01 word at step 2
        bus.opcode = 4'h3; bus.start = 1'b1;
        tick(); bus.start = 1'b0;
        exp_chk("flags_s0", 18'h00020, 3'd0, 1'b1, 1'b0, 1'b0);
        tick();
        exp_chk("flags_s1", 18'h00021, 3'd1, 1'b0, 1'b0, 1'b0);
        bus.flags_in = 2'b01; bus.flags_we = 1'b1;
        tick(); bus.flags_we = 1'b0;
        exp_chk("flags_s2_new", 18'h00032, 3'd2, 1'b0, 1'b0, 1'b0);
        tick();
        exp_chk("flags_wrap", 18'h00030, 3'd0, 1'b1, 1'b0, 1'b0);
        bus.abort = 1'b1; bus.flags_in = 2'b00; bus.flags_we = 1'b1;
        tick(); bus.abort = 1'b0; bus.flags_we = 1'b0;
        exp_chk("flags_abort", '0, '0, 1'b0, 1'b0, 1'b0);

        // Halt word shown for one cycle, then HALTED; start resumes at step 0
        bus.opcode = 4'h4; bus.start = 1'b1;
        tick(); bus.start = 1'b0;
        exp_chk("halt_s0", 18'h00040, 3'd0, 1'b1, 1'b0, 1'b0);
        tick();
        exp_chk("halt_word", 18'h20041, 3'd1, 1'b0, 1'b0, 1'b0);
        tick();
        exp_chk("halted", '0, '0, 1'b0, 1'b1, 1'b0);
        tick();
        exp_chk("halted_hold", '0, '0, 1'b0, 1'b1, 1'b0);
        bus.start = 1'b1;
        tick(); bus.start = 1'b0;
        exp_chk("halt_resume", 18'h00040, 3'd0, 1'b1, 1'b0, 1'b0);
        bus.abort = 1'b1;
        tick(); bus.abort = 1'b0;
        exp_chk("halt_abort", '0, '0, 1'b0, 1'b0, 1'b0);

        // Write attempt while running is refused and flagged for one cycle
        bus.opcode = 4'h1; bus.start = 1'b1;
        tick(); bus.start = 1'b0;
        exp_chk("wr_run_s0", 18'h00001, 3'd0, 1'b1, 1'b0, 1'b0);
        bus.wr_en = 1'b1; bus.wr_addr = {4'h1, 2'b00, 3'd1}; bus.wr_data = 19'h01234;
        tick(); bus.wr_en = 1'b0;
        exp_chk("wr_err_pulse", 18'h00002, 3'd1, 1'b0, 1'b0, 1'b1);
        tick();
        exp_chk("wr_err_clear", 18'h00004, 3'd2, 1'b0, 1'b0, 1'b0);
        bus.abort = 1'b1;
        tick(); bus.abort = 1'b0;
        exp_chk("wr_abort", '0, '0, 1'b0, 1'b0, 1'b0);
        bus.start = 1'b1;
        tick(); bus.start = 1'b0;
        tick();
        exp_chk("wr_readback", 18'h00002, 3'd1, 1'b0, 1'b0, 1'b0);

        // Abort beats start in the same cycle
        bus.abort = 1'b1; bus.start = 1'b1;
        tick(); bus.abort = 1'b0; bus.start = 1'b0;
        exp_chk("abort_over_start", '0, '0, 1'b0, 1'b0, 1'b0);

        // Write coinciding with start from IDLE lands before the first read
        bus.wr_en = 1'b1; bus.wr_addr = {4'h1, 2'b00, 3'd0}; bus.wr_data = 19'h00008;
        bus.start = 1'b1;
        tick(); bus.wr_en = 1'b0; bus.start = 1'b0;
        exp_chk("wr_with_start", 18'h00008, 3'd0, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        exp_chk("rst_pre_s2", 18'h00004, 3'd2, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset between edges
        #2 rst_n = 1'b0;
        #1;
        exp_chk("async_reset", '0, '0, 1'b0, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        exp_chk("idle_after_rst", '0, '0, 1'b0, 1'b0, 1'b0);
        bus.start = 1'b1;
        tick(); bus.start = 1'b0;
        exp_chk("ram_kept_s0", 18'h00008, 3'd0, 1'b1, 1'b0, 1'b0);
        tick();
        exp_chk("ram_kept_s1", 18'h00002, 3'd1, 1'b0, 1'b0, 1'b0);
        tick();
        exp_chk("ram_kept_s2", 18'h00004, 3'd2, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/microcode_sequencer.md
MICROCODE_SEQUENCER -- requirements
Module: microcode_sequencer

Interface
REQ-001 SHALL have parameter OP_W, default 4, opcode width.
REQ-002 SHALL have parameter FLAG_W, default 2, flag width.
REQ-003 SHALL have parameter STEP_W, default 3, step counter width (max 2^STEP_W steps per instruction).
REQ-004 SHALL have parameter CTRL_W, default 18, control word width.
REQ-005 SHALL have parameter HLT_BIT, default 17, index of the halt bit within the control word.
REQ-006 Port: clk, input, 1, single clock; all state updates on rising edge.
REQ-007 Port: rst_n, input, 1, asynchronous active-low reset.
REQ-008 Port: opcode, input, OP_W, current instruction opcode from the external instruction register.
REQ-009 Port: flags_in, input, FLAG_W, ALU flags.
REQ-010 Port: flags_we, input, 1, latch flags_in into flags_q.
REQ-011 Port: start, input, 1, begin or resume execution.
REQ-012 Port: abort, input, 1, synchronous return to IDLE.
REQ-013 Port: wr_en, input, 1, microcode write strobe.
REQ-014 Port: wr_addr, input, AW = OP_W+FLAG_W+STEP_W, microcode word address.
REQ-015 Port: wr_data, input, CTRL_W+1, microcode word; bit CTRL_W is END, bits CTRL_W-1:0 are control bits.
REQ-016 Port: ctrl_out, output, CTRL_W, active control word.
REQ-017 Port: step_out, output, STEP_W, current step.
REQ-018 Port: fetch, output, 1, high while in RUN with step 0.
REQ-019 Port: halted, output, 1, high in HALTED.
REQ-020 Port: wr_err, output, 1, one-cycle pulse on a rejected write.

Function
REQ-021 SHALL hold a microcode RAM of 2^AW words of CTRL_W+1 bits, with asynchronous read and synchronous write.
REQ-022 SHALL form the read address as {opcode, flags_q, step}, with opcode in the MSBs.
REQ-023 SHALL implement exactly three states: IDLE, RUN, HALTED.
REQ-024 ctrl_out SHALL equal RAM[addr][CTRL_W-1:0] in RUN, combinationally, with zero latency from a step, opcode or flags_q change; ctrl_out SHALL be 0 in IDLE and HALTED.
REQ-025 In RUN, each cycle, step SHALL be set to 0 if the current word has END=1 or step = 2^STEP_W-1 (wrap); otherwise step SHALL increment by 1.
REQ-026 In RUN, if the current word has bit HLT_BIT=1, the next state SHALL be HALTED and step SHALL become 0; halt takes priority over END and increment. ctrl_out SHALL show the halting word for that one cycle.
REQ-027 start SHALL move IDLE or HALTED to RUN with step=0; start SHALL be ignored in RUN.
REQ-028 abort SHALL move any state to IDLE with step=0 on the next edge; abort SHALL have priority over start, halt and step advance.
REQ-029 flags_we SHALL update flags_q on the next edge in any state; the new flags_q SHALL affect the address from the following cycle.
REQ-030 flags_we coinciding with a step advance SHALL apply both updates on the same edge.
REQ-031 wr_en in IDLE or HALTED SHALL write wr_data to RAM[wr_addr] on the edge.
REQ-032 wr_en in RUN SHALL NOT write and SHALL pulse wr_err high for exactly the next cycle.
REQ-033 A write coinciding with a start from IDLE or HALTED SHALL complete, because the state is sampled before the edge.
REQ-034 step_out SHALL equal the step register in all states.
REQ-035 fetch SHALL be (state==RUN && step==0).
REQ-036 halted SHALL be (state==HALTED).

Reset
REQ-037 On rst_n low, state=IDLE, step=0, flags_q=0, wr_err=0, and hence ctrl_out=0, fetch=0, halted=0, immediately and without waiting for clk.
REQ-038 RAM contents SHALL NOT be reset; the bench SHALL load every used address before start.
REQ-039 Reset asserted mid-RUN SHALL abandon the instruction; after release the block SHALL stay in IDLE until start.

Verification
REQ-040 Scenario: load opcode 0x1, flags 00, steps 0..2 with ctrl 0x00001, 0x00002, 0x00004|END; start -> ctrl_out sequence 0x00001, 0x00002, 0x00004, then 0x00001 again with fetch=1; step_out sequence 0,1,2,0.
REQ-041 Scenario: opcode 0x2 with no END in any of its 8 words -> step_out sequence 0..7 then wraps to 0; fetch asserted once per 8 cycles.
REQ-042 Scenario: opcode 0x3, flags 01 vs 00, differing words at step 2; flags_we pulsed during step 1 -> step 2 ctrl_out equals the word for flags=01.
REQ-043 Scenario: word at step 1 has bit 17 set -> ctrl_out=that word for 1 cycle, then halted=1, ctrl_out=0, step_out=0; start -> RUN resumes at step 0.
REQ-044 Scenario: wr_en during RUN -> RAM unchanged on readback after abort, wr_err high exactly 1 cycle; abort and start in the same cycle -> IDLE.
REQ-045 Scenario: rst_n asserted at step 2 between clk edges -> ctrl_out, step_out and fetch drop to 0 asynchronously; RAM words remain intact after release.
